move_input_conditioner: RTL

//   Front-end for the tic-tac-toe game FSM. Synchronises and debounces the raw
//   KEY buttons and synchronises the 9 move switches. Emits one single-cycle

---
 rtl/move_input_conditioner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/move_input_conditioner.sv
// Input front-end for the tic-tac-toe game FSM: synchronises and debounces the
// select/clear keys, synchronises the move switches and emits move/clear strobes.

module move_key_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press_c
);
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_n;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;
    logic                   expired;

    assign synced  = ~sync_n[SYNC_STAGES-1];
    assign expired = (cnt == CNT_W'(DB_CYCLES));
    // Press event is the edge on which the debounced level goes released->pressed
    assign press_c = synced & ~level & expired;

    // Counter measures how long the synced level has disagreed with the debounced one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_n <= '1;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_n <= {sync_n[SYNC_STAGES-2:0], raw_n};
            if (synced == level) begin
                cnt <= '0;
            end else if (expired) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module move_input_conditioner #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       MAX10_CLK1_50,
    input  logic       rst,
    input  logic       key_select_n,
    input  logic       key_clear_n,
    input  logic [8:0] sw,
    output logic       move_pulse,
    output logic [8:0] move_onehot,
    output logic [3:0] move_idx,
    output logic       move_err,
    output logic       clear_pulse,
    output logic       sel_level
);
    localparam int unsigned DB_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned SQUARES   = 9;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t             state;
    logic               sel_press;
    logic               clr_press;
    logic               clr_level;
    logic [SQUARES-1:0] sw_pipe [SYNC_STAGES];
    logic [SQUARES-1:0] sw_s;
    logic [IDX_W-1:0]   idx_c;
    logic               sw_valid_c;

    move_key_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_sel_db (
        .clk     (MAX10_CLK1_50),
        .rst     (rst),
        .raw_n   (key_select_n),
        .level   (sel_level),
        .press_c (sel_press)
    );

    move_key_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) u_clr_db (
        .clk     (MAX10_CLK1_50),
        .rst     (rst),
        .raw_n   (key_clear_n),
        .level   (clr_level),
        .press_c (clr_press)
    );

    // Switch synchroniser
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sw_pipe[i] <= '0;
        end else begin
            sw_pipe[0] <= sw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sw_pipe[i] <= sw_pipe[i-1];
        end
    end

    assign sw_s       = sw_pipe[SYNC_STAGES-1];
    assign sw_valid_c = $onehot(sw_s);

    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(SQUARES); i++) begin
            if (sw_s[i]) idx_c = IDX_W'(i);
        end
    end

    // Press FSM: the switch is evaluated as EVAL is entered so its strobe is visible during EVAL
    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            move_pulse  <= 1'b0;
            move_err    <= 1'b0;
            clear_pulse <= 1'b0;
            move_onehot <= '0;
            move_idx    <= '0;
        end else begin
            move_pulse  <= 1'b0;
            move_err    <= 1'b0;
            clear_pulse <= clr_press;
            if (clr_press) begin
                state <= (sel_level | sel_press) ? WAIT_REL : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (sel_press) begin
                            state <= EVAL;
                            if (sw_valid_c) begin
                                move_pulse  <= 1'b1;
                                move_onehot <= sw_s;
                                move_idx    <= idx_c;
                            end else begin
                                move_err <= 1'b1;
                            end
                        end
                    end
                    EVAL:     state <= WAIT_REL;
                    WAIT_REL: if (!sel_level) state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    logic unused_ok;
    assign unused_ok = clr_level;
endmodule
